// File: rtl/forth_imem_loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory boot loader.
// Pure declarations: no latency, no flow control.
package forth_imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         INSTR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CSUM
    } load_state_t;

endpackage

// File: rtl/forth_gap_timer.sv
// Inter-byte gap timer: reloads on every accepted byte; expire is asserted on the last idle clock.
// Combinational expire output; it never stalls anything.
module forth_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT_CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A count of 1 with no byte this clock means this is the TIMEOUT_CYCLES-th idle clock.
    assign expire = run && !load && (count == CW'(1));

endmodule

// File: rtl/forth_imem_loader.sv
// Framed serial image loader: writes words to instruction RAM and holds the core in reset until a good image lands.
// Writes and flags are registered one cycle after the causing byte; rx_ready is always high out of reset.
module forth_imem_loader
    import forth_imem_loader_pkg::*;
#(
    parameter int IADDR_WIDTH    = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [IADDR_WIDTH-1:0] imem_waddr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   imem_we,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << IADDR_WIDTH;

    load_state_t            state, state_n;
    logic [IADDR_WIDTH-1:0] word_addr, word_addr_n;
    logic [15:0]            words_left, words_left_n;
    logic [7:0]             len_lo, len_lo_n;
    logic [7:0]             lo_byte, lo_byte_n;
    logic [7:0]             sum, sum_n;
    logic [IADDR_WIDTH-1:0] imem_waddr_n;
    logic [INSTR_WIDTH-1:0] imem_wdata_n;
    logic                   imem_we_n, core_reset_n, load_done_n, load_err_n;

    logic        take;
    logic        expire;
    logic [7:0]  sum_next;
    logic [15:0] len;

    assign take     = rx_valid && rx_ready;
    assign sum_next = sum + rx_data;
    assign len      = {rx_data, len_lo};

    forth_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .load  (take),
        .run   (state != ST_IDLE),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_addr  <= '0;
            words_left <= '0;
            len_lo     <= '0;
            lo_byte    <= '0;
            sum        <= '0;
        end else begin
            state      <= state_n;
            rx_ready   <= 1'b1;
            imem_we    <= imem_we_n;
            imem_waddr <= imem_waddr_n;
            imem_wdata <= imem_wdata_n;
            core_reset <= core_reset_n;
            load_done  <= load_done_n;
            load_err   <= load_err_n;
            word_addr  <= word_addr_n;
            words_left <= words_left_n;
            len_lo     <= len_lo_n;
            lo_byte    <= lo_byte_n;
            sum        <= sum_n;
        end
    end

    always_comb begin
        state_n      = state;
        imem_we_n    = 1'b0;
        imem_waddr_n = imem_waddr;
        imem_wdata_n = imem_wdata;
        core_reset_n = core_reset;
        load_done_n  = load_done;
        load_err_n   = load_err;
        word_addr_n  = word_addr;
        words_left_n = words_left;
        len_lo_n     = len_lo;
        lo_byte_n    = lo_byte;
        sum_n        = sum;

        if (take) begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_n      = ST_LEN_LO;
                        load_done_n  = 1'b0;
                        load_err_n   = 1'b0;
                        core_reset_n = 1'b1;
                        sum_n        = '0;
                        word_addr_n  = '0;
                    end
                end
                ST_LEN_LO: begin
                    len_lo_n = rx_data;
                    sum_n    = sum_next;
                    state_n  = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    sum_n        = sum_next;
                    words_left_n = len;
                    if ({1'b0, len} > MAX_WORDS) begin
                        load_err_n = 1'b1;
                        state_n    = ST_IDLE;
                    end else if (len == 16'd0) begin
                        state_n = ST_CSUM;
                    end else begin
                        state_n = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    lo_byte_n = rx_data;
                    sum_n     = sum_next;
                    state_n   = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    sum_n        = sum_next;
                    imem_we_n    = 1'b1;
                    imem_waddr_n = word_addr;
                    imem_wdata_n = {rx_data, lo_byte};
                    word_addr_n  = word_addr + 1'b1;
                    words_left_n = words_left - 1'b1;
                    state_n      = (words_left == 16'd1) ? ST_CSUM : ST_DATA_LO;
                end
                ST_CSUM: begin
                    if (sum_next == 8'h00) begin
                        load_done_n  = 1'b1;
                        core_reset_n = 1'b0;
                    end else begin
                        load_err_n = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (expire) begin
            load_err_n = 1'b1;
            state_n    = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_forth_imem_loader.sv
// Bench for forth_imem_loader: frame-position reference model checked every cycle, plus directed literal checks.
module tb_forth_imem_loader;

    localparam int IW    = 4;
    localparam int T     = 12;
    localparam int DEPTH = 1 << IW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [IW-1:0] imem_waddr;
    logic [15:0]   imem_wdata;
    logic          imem_we, core_reset, load_done, load_err;

    forth_imem_loader #(
        .IADDR_WIDTH   (IW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .imem_we   (imem_we),
        .core_reset(core_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame by byte index, not by decode state.
    bit m_rdy = 0, m_we = 0, m_core = 1, m_done = 0, m_err = 0;
    int m_addr = 0, m_data = 0;
    bit in_frame = 0;
    int idx = 0, n = 0, sum = 0, lo = 0, gap = 0;

    always @(posedge clk) begin
        bit acc;
        int b;
        acc  = rx_valid && m_rdy;
        b    = int'(rx_data);
        m_we = 0;
        if (reset) begin
            m_rdy = 0; m_core = 1; m_done = 0; m_err = 0;
            m_addr = 0; m_data = 0; in_frame = 0;
        end else begin
            m_rdy = 1;
            if (acc) begin
                gap = 0;
                if (!in_frame) begin
                    if (b == 'hA5) begin
                        in_frame = 1; idx = 0; sum = 0;
                        m_done = 0; m_err = 0; m_core = 1;
                    end
                end else begin
                    idx++;
                    sum += b;
                    if (idx == 1) begin
                        n = b;
                    end else if (idx == 2) begin
                        n += b * 256;
                        if (n > DEPTH) begin
                            m_err = 1; in_frame = 0;
                        end
                    end else if (idx <= 2 + 2 * n) begin
                        if (idx % 2 == 1) begin
                            lo = b;
                        end else begin
                            m_we   = 1;
                            m_addr = ((idx - 4) / 2) % DEPTH;
                            m_data = b * 256 + lo;
                        end
                    end else begin
                        if (sum % 256 == 0) begin
                            m_done = 1; m_core = 0;
                        end else begin
                            m_err = 1;
                        end
                        in_frame = 0;
                    end
                end
            end else if (in_frame) begin
                gap++;
                if (gap == T) begin
                    m_err = 1; in_frame = 0;
                end
            end
        end
    end

    int unsigned wlog[$];

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("rx_ready",   32'(rx_ready),   32'(m_rdy));
            check("imem_we",    32'(imem_we),    32'(m_we));
            check("imem_waddr", 32'(imem_waddr), m_addr);
            check("imem_wdata", 32'(imem_wdata), m_data);
            check("core_reset", 32'(core_reset), 32'(m_core));
            check("load_done",  32'(load_done),  32'(m_done));
            check("load_err",   32'(load_err),   32'(m_err));
            if (imem_we === 1'b1) wlog.push_back({16'(imem_waddr), imem_wdata});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends the first len bytes of seq, most significant byte first, back-to-back.
    task automatic send_seq(input int len, input logic [63:0] seq);
        for (int i = 0; i < len; i++) send(seq[8*(len-1-i) +: 8]);
    endtask

    task automatic send_frame(input int nw, input bit good, input int maxgap, input int cut);
        logic [7:0] q[$];
        int s;
        int c;
        logic [7:0] b;
        s = 0;
        q.push_back(8'hA5);
        q.push_back(nw[7:0]);
        q.push_back(nw[15:8]);
        s = nw[7:0] + nw[15:8];
        for (int i = 0; i < 2 * nw; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            s += int'(b);
        end
        c = (256 - (s % 256)) % 256;
        if (!good) c = (c + 1 + int'($urandom_range(0, 254))) % 256;
        q.push_back(c[7:0]);
        for (int i = 0; i < q.size(); i++) begin
            if (i == cut) begin
                idle(T + 2);
                return;
            end
            send(q[i]);
            idle(int'($urandom_range(0, maxgap)));
        end
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        check("rst_rx_ready",   32'(rx_ready),   0);
        check("rst_imem_we",    32'(imem_we),    0);
        check("rst_core_reset", 32'(core_reset), 1);
        check("rst_load_done",  32'(load_done),  0);
        check("rst_load_err",   32'(load_err),   0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", 32'(rx_ready), 1);

        wlog.delete();
        send_seq(8, 64'hA5_02_00_34_12_78_56_EA);
        check("good_done",   32'(load_done),  1);
        check("good_core",   32'(core_reset), 0);
        check("good_err",    32'(load_err),   0);
        check("good_nwr",    wlog.size(),     2);
        if (wlog.size() == 2) begin
            check("good_w0", wlog[0], 32'h0000_1234);
            check("good_w1", wlog[1], 32'h0001_5678);
        end
        tick();
        check("we_single_pulse", 32'(imem_we), 0);

        wlog.delete();
        send_seq(8, 64'hA5_02_00_34_12_78_56_EB);
        check("bad_err",  32'(load_err),   1);
        check("bad_core", 32'(core_reset), 1);
        check("bad_done", 32'(load_done),  0);
        check("bad_nwr",  wlog.size(),     2);

        wlog.delete();
        send_seq(4, 64'hA5_00_00_00);
        check("empty_done", 32'(load_done),  1);
        check("empty_core", 32'(core_reset), 0);
        check("empty_nwr",  wlog.size(),     0);

        wlog.delete();
        send_seq(4, 64'hA5_01_00_CD);
        idle(T - 1);
        check("timeout_not_yet", 32'(load_err), 0);
        idle(1);
        check("timeout_err",  32'(load_err),   1);
        check("timeout_core", 32'(core_reset), 1);
        check("timeout_nwr",  wlog.size(),     0);
        send(8'hA5);
        check("idle_after_timeout", 32'(load_err), 0);
        send_seq(3, 64'h00_00_00);
        check("reload_done", 32'(load_done), 1);

        send(8'hA5);
        check("resync_core", 32'(core_reset), 1);
        check("resync_done", 32'(load_done),  0);
        wlog.delete();
        send_seq(5, 64'h01_00_EF_BE_52);
        check("beef_nwr",  wlog.size(),     1);
        if (wlog.size() == 1) check("beef_w0", wlog[0], 32'h0000_BEEF);
        check("beef_core", 32'(core_reset), 0);

        send_seq(3, 64'hA5_02_00);
        reset = 1'b1;
        idle(2);
        check("midrst_rx_ready", 32'(rx_ready),   0);
        check("midrst_waddr",    32'(imem_waddr), 0);
        check("midrst_wdata",    32'(imem_wdata), 0);
        check("midrst_core",     32'(core_reset), 1);
        check("midrst_done",     32'(load_done),  0);
        reset = 1'b0;
        tick();
        wlog.delete();
        send_seq(6, 64'hA5_01_00_22_11_CC);
        check("fresh_nwr",  wlog.size(),    1);
        if (wlog.size() == 1) check("fresh_w0", wlog[0], 32'h0000_1122);
        check("fresh_done", 32'(load_done), 1);

        wlog.delete();
        send_frame(DEPTH, 1'b1, 0, -1);
        check("full_nwr",  wlog.size(),    DEPTH);
        if (wlog.size() == DEPTH) check("full_last_addr", wlog[DEPTH-1] >> 16, DEPTH - 1);
        check("full_done", 32'(load_done), 1);

        wlog.delete();
        send_seq(3, 64'hA5_11_00);
        check("over_err",  32'(load_err),   1);
        check("over_core", 32'(core_reset), 1);
        idle(T + 2);
        check("over_nwr",  wlog.size(),     0);

        for (int it = 0; it < 60; it++) begin
            int mode;
            mode = int'($urandom_range(0, 7));
            if (mode == 0) begin
                logic [7:0] nb;
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h00;
                send(nb);
            end else if (mode == 1) begin
                send_frame(int'($urandom_range(0, DEPTH + 2)), 1'b1, 2,
                           int'($urandom_range(1, 8)));
            end else begin
                send_frame(int'($urandom_range(0, DEPTH + 2)), mode != 2, 3, -1);
            end
            idle(int'($urandom_range(0, 3)));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
